// File: rtl/if_dbg_pkg.sv
// Shared definitions for the IF-stage debug controller: FSM state set,
// command bytes, halt encoding and default sizing.
package if_dbg_pkg;

   // Default instruction-memory capacity (32-bit words) and drain length
   localparam int MAX_WORDS_DEF = 64;
   localparam int DRAIN_CYC_DEF = 4;

   // Instruction encoding that ends a run (decode treats it as a NOP)
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   // Command bytes on the debug byte channel
   localparam logic [7:0] CMD_LOAD  = 8'h4C;
   localparam logic [7:0] CMD_RUN   = 8'h52;
   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [7:0] CMD_ABORT = 8'h58;

   // Controller state enumeration (plain constants for legacy tools)
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_GET_LEN  = 3'd1;
   localparam state_t ST_GET_BYTE = 3'd2;
   localparam state_t ST_WRITE    = 3'd3;
   localparam state_t ST_RUN      = 3'd4;
   localparam state_t ST_DRAIN    = 3'd5;
   localparam state_t ST_STEP     = 3'd6;

endpackage

// File: rtl/prog_word_packer.sv
// Byte-to-word packer: shifts payload bytes in MSB first and flags the byte
// that completes a 32-bit word.
module prog_word_packer (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_ready
);

   logic [1:0]  r_idx;
   logic [31:0] r_word;

   // Shift accepted bytes in; the 2-bit index wraps to 0 after the fourth
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_clear) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_byte_valid) begin
         r_word <= {r_word[23:0], i_byte};
         r_idx  <= r_idx + 2'd1;
      end
   end

   assign o_word       = r_word;
   // High during the cycle whose accepted byte completes the word
   assign o_word_ready = i_byte_valid && (r_idx == 2'd3);

endmodule

// File: rtl/if_prog_ctrl.sv
// Debug-side IF-stage controller: loads programs into instruction memory from
// a byte command channel, gates the pipeline clock enable for run/step, and
// drains the pipeline with the PC frozen once the halt word is fetched.
//
// Byte channel handshake: a byte transfers on a rising edge where
// i_rx_valid && o_rx_ready; o_rx_ready is registered and depends only on the
// controller state, never combinationally on i_rx_valid.
module if_prog_ctrl
   import if_dbg_pkg::*;
#(
   parameter int MAX_WORDS = MAX_WORDS_DEF,
   parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_rx_ready,
   input  logic [31:0] i_instruction,
   output logic        o_write_en,
   output logic [31:0] o_data,
   output logic [31:0] o_addr_wr,
   output logic        o_clk_en,
   output logic        o_pc_stall,
   output logic        o_pipe_reset,
   output logic        o_busy,
   output logic        o_done,
   output state_t      o_dbg_state
);

   state_t      r_state;
   logic        r_rx_ready;
   logic        r_write_en;
   logic        r_clk_en;
   logic        r_pc_stall;
   logic        r_pipe_reset;
   logic        r_busy;
   logic        r_done;
   logic [7:0]  r_count;
   logic [7:0]  r_addr;
   logic [7:0]  r_drain;

   state_t      w_state_nxt;
   logic        w_done_nxt;
   logic        w_accept;
   logic        w_halt;
   logic        w_abort;
   logic [7:0]  w_len;
   logic        w_pack_valid;
   logic        w_pack_clear;
   logic        w_word_ready;
   logic [31:0] w_word;

   assign w_accept     = i_rx_valid && r_rx_ready;
   assign w_halt       = (i_instruction == HALT_WORD) && r_clk_en;
   assign w_abort      = w_accept && (i_rx_data == CMD_ABORT);
   assign w_len        = (int'(i_rx_data) > MAX_WORDS) ? 8'(MAX_WORDS) : i_rx_data;
   assign w_pack_valid = w_accept && (r_state == ST_GET_BYTE);
   assign w_pack_clear = (r_state == ST_GET_LEN);

   prog_word_packer u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (w_pack_clear),
      .i_byte_valid (w_pack_valid),
      .i_byte       (i_rx_data),
      .o_word       (w_word),
      .o_word_ready (w_word_ready)
   );

   // Next-state decode; w_done_nxt marks transitions that complete a command
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (i_rx_data == CMD_LOAD)      w_state_nxt = ST_GET_LEN;
               else if (i_rx_data == CMD_RUN)  w_state_nxt = ST_RUN;
               else if (i_rx_data == CMD_STEP) w_state_nxt = ST_STEP;
            end
         end
         ST_GET_LEN: begin
            if (w_accept) begin
               if (i_rx_data == 8'd0) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_GET_BYTE;
               end
            end
         end
         ST_GET_BYTE: begin
            if (w_word_ready) w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (r_count == 8'd1) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_GET_BYTE;
            end
         end
         ST_RUN: begin
            // Halt and abort together still enter DRAIN exactly once
            if (w_halt || w_abort) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (r_drain == 8'd0) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         ST_STEP: begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register and Moore outputs registered from the next state
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= ST_IDLE;
         r_rx_ready   <= 1'b1;
         r_write_en   <= 1'b0;
         r_clk_en     <= 1'b0;
         r_pc_stall   <= 1'b0;
         r_pipe_reset <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_rx_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GET_LEN) ||
                         (w_state_nxt == ST_GET_BYTE) || (w_state_nxt == ST_RUN);
         r_write_en   <= (w_state_nxt == ST_WRITE);
         r_clk_en     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN) ||
                         (w_state_nxt == ST_STEP);
         r_pc_stall   <= (w_state_nxt == ST_DRAIN);
         r_pipe_reset <= (w_state_nxt == ST_GET_LEN) || (w_state_nxt == ST_GET_BYTE) ||
                         (w_state_nxt == ST_WRITE);
         r_busy       <= (w_state_nxt != ST_IDLE);
         r_done       <= w_done_nxt;
      end
   end

   // Word count, write address and drain down-counter
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_count <= '0;
         r_addr  <= '0;
         r_drain <= '0;
      end else begin
         if ((r_state == ST_GET_LEN) && w_accept && (i_rx_data != 8'd0)) begin
            r_count <= w_len;
            r_addr  <= '0;
         end
         // Address is 8 bits wide, so it wraps after the last 64th word
         if (r_state == ST_WRITE) begin
            r_count <= r_count - 8'd1;
            r_addr  <= r_addr + 8'd4;
         end
         if ((r_state == ST_RUN) && (w_state_nxt == ST_DRAIN)) begin
            r_drain <= 8'(DRAIN_CYC - 1);
         end else if ((r_state == ST_DRAIN) && (r_drain != 8'd0)) begin
            r_drain <= r_drain - 8'd1;
         end
      end
   end

   assign o_rx_ready   = r_rx_ready;
   assign o_write_en   = r_write_en;
   assign o_data       = w_word;
   assign o_addr_wr    = {24'd0, r_addr};
   assign o_clk_en     = r_clk_en;
   assign o_pc_stall   = r_pc_stall;
   assign o_pipe_reset = r_pipe_reset;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_if_prog_ctrl.sv
// Testbench for if_prog_ctrl: directed scenarios plus randomized command
// traffic, checked every cycle against a mode-level behavioural model and a
// write scoreboard.
module tb_if_prog_ctrl;

  localparam logic [7:0]  C_LOAD  = 8'h4C;
  localparam logic [7:0]  C_RUN   = 8'h52;
  localparam logic [7:0]  C_STEP  = 8'h53;
  localparam logic [7:0]  C_ABORT = 8'h58;
  localparam logic [31:0] HALT    = 32'hFFFF_FFFF;
  localparam int          CAP     = 64;
  localparam int          DRAIN   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] instr = 32'h0000_0020;

  logic        o_rx_ready, o_write_en, o_clk_en, o_pc_stall;
  logic        o_pipe_reset, o_busy, o_done;
  logic [31:0] o_data, o_addr_wr;
  logic [2:0]  dbg_state;

  if_prog_ctrl dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .o_rx_ready   (o_rx_ready),
    .i_instruction(instr),
    .o_write_en   (o_write_en),
    .o_data       (o_data),
    .o_addr_wr    (o_addr_wr),
    .o_clk_en     (o_clk_en),
    .o_pc_stall   (o_pc_stall),
    .o_pipe_reset (o_pipe_reset),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_wr, n_done, n_stall, n_clk;
  logic [7:0]  last_wr_addr;
  logic [39:0] exp_q[$];   // {addr[7:0], data[31:0]}

  logic [7:0] load2_seq [10] = '{8'h4C, 8'h02, 8'h12, 8'h34, 8'h56,
                                 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_LEN, M_BYTES, M_WRITE, M_RUN, M_DRAIN, M_STEP} mode_e;
  mode_e       m_mode;
  int          m_left, m_addr, m_drain;
  bit          m_done;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_word;

  function automatic void m_reset();
    m_mode = M_IDLE; m_left = 0; m_addr = 0; m_drain = 0; m_done = 0;
    m_bytes.delete(); m_word = '0;
  endfunction

  function automatic bit e_ready();
    return (m_mode == M_IDLE) || (m_mode == M_LEN) || (m_mode == M_BYTES) || (m_mode == M_RUN);
  endfunction
  function automatic bit e_clk_en();
    return (m_mode == M_RUN) || (m_mode == M_DRAIN) || (m_mode == M_STEP);
  endfunction
  function automatic bit e_pipe_reset();
    return (m_mode == M_LEN) || (m_mode == M_BYTES) || (m_mode == M_WRITE);
  endfunction

  // Advance the model by one clock using the inputs present at the edge
  function automatic void m_step();
    bit acc;
    acc = rx_valid && e_ready();
    m_done = 0;
    if (m_mode == M_IDLE) begin
      if (acc && rx_data == C_LOAD) m_mode = M_LEN;
      else if (acc && rx_data == C_RUN) m_mode = M_RUN;
      else if (acc && rx_data == C_STEP) m_mode = M_STEP;
    end else if (m_mode == M_LEN) begin
      if (acc) begin
        if (rx_data == 8'd0) begin
          m_mode = M_IDLE; m_done = 1;
        end else begin
          m_left = (int'(rx_data) > CAP) ? CAP : int'(rx_data);
          m_addr = 0; m_bytes.delete(); m_mode = M_BYTES;
        end
      end
    end else if (m_mode == M_BYTES) begin
      if (acc) begin
        m_bytes.push_back(rx_data);
        if (m_bytes.size() == 4) begin
          m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_bytes.delete(); m_mode = M_WRITE;
        end
      end
    end else if (m_mode == M_WRITE) begin
      m_addr = (m_addr + 4) % 256;
      m_left = m_left - 1;
      if (m_left == 0) begin m_mode = M_IDLE; m_done = 1; end
      else m_mode = M_BYTES;
    end else if (m_mode == M_RUN) begin
      if (instr == HALT || (acc && rx_data == C_ABORT)) begin
        m_mode = M_DRAIN; m_drain = DRAIN;
      end
    end else if (m_mode == M_DRAIN) begin
      m_drain = m_drain - 1;
      if (m_drain == 0) begin m_mode = M_IDLE; m_done = 1; end
    end else begin
      m_mode = M_IDLE; m_done = 1;
    end
  endfunction

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else m_step();
    #1;
    chk("rx_ready", o_rx_ready, e_ready());
    chk("write_en", o_write_en, m_mode == M_WRITE);
    chk("clk_en", o_clk_en, e_clk_en());
    chk("pc_stall", o_pc_stall, m_mode == M_DRAIN);
    chk("pipe_reset", o_pipe_reset, e_pipe_reset());
    chk("busy", o_busy, m_mode != M_IDLE);
    chk("done", o_done, m_done);
    chk("addr_wr", o_addr_wr, m_addr);
    chk("wr_and_clk_en", o_write_en & o_clk_en, 1'b0);
    if (m_mode == M_WRITE) chk("data", o_data, m_word);
    if (o_write_en === 1'b1) begin
      n_wr++;
      last_wr_addr = o_addr_wr[7:0];
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_unexpected_write: got addr %0h data %0h, required no write", o_addr_wr, o_data);
      end else begin
        chk("sb_write", {o_addr_wr[7:0], o_data}, exp_q.pop_front());
      end
    end
    if (o_done === 1'b1)     n_done++;
    if (o_pc_stall === 1'b1) n_stall++;
    if (o_clk_en === 1'b1)   n_clk++;
  end

  // ---------------- driver tasks ----------------
  task automatic clr_cnt();
    n_wr = 0; n_done = 0; n_stall = 0; n_clk = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap = 0);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (o_rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (o_rx_ready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: got rx_ready %b, required 1 within 200 cycles", o_rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (o_done !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: got done %b, required 1 within %0d cycles", o_done, limit);
    end
  endtask

  task automatic load_prog(input int n, input int max_gap);
    int nw;
    logic [31:0] w;
    send_byte(C_LOAD, $urandom_range(0, max_gap));
    send_byte(8'(n), $urandom_range(0, max_gap));
    nw = (n > CAP) ? CAP : n;
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      exp_q.push_back({8'(i * 4), w});
      for (int b = 0; b < 4; b++) send_byte(w[31 - 8*b -: 8], $urandom_range(0, max_gap));
    end
  endtask

  function automatic logic [31:0] rand_nonhalt();
    logic [31:0] v;
    v = $urandom;
    if (v == HALT) v = 32'h0;
    return v;
  endfunction

  function automatic logic [7:0] noise_byte(input bit allow_abort);
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    while (v == C_LOAD || v == C_RUN || v == C_STEP || (!allow_abort && v == C_ABORT))
      v = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_checks++; n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    m_reset();
    clr_cnt();
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", o_rx_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_write_en", o_write_en, 1'b0);
    chk("rst_clk_en", o_clk_en, 1'b0);
    chk("rst_addr", o_addr_wr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word load, valid held high
    clr_cnt();
    exp_q.push_back(40'h00_1234_5678);
    exp_q.push_back(40'h04_9ABC_DEF0);
    for (int i = 0; i < 10; i++) send_byte(load2_seq[i]);
    wait_done(50);
    @(negedge clk);
    chk("load2_writes", n_wr, 2);
    chk("load2_done", n_done, 1);

    // Zero-length load
    clr_cnt();
    send_byte(C_LOAD);
    send_byte(8'h00);
    chk("zero_done", o_done, 1'b1);
    chk("zero_busy", o_busy, 1'b0);
    @(negedge clk);
    chk("zero_done_pulse", o_done, 1'b0);
    chk("zero_writes", n_wr, 0);

    // Run until the halt word is fetched
    clr_cnt();
    send_byte(C_RUN);
    repeat (5) @(negedge clk);
    instr = HALT;
    wait_done(50);
    chk("halt_clk_en_off", o_clk_en, 1'b0);
    chk("halt_stall_cycles", n_stall, 4);
    chk("halt_clk_cycles", n_clk, 10);
    instr = 32'h0000_0020;
    @(negedge clk);

    // Single step with a stray byte offered during STEP
    clr_cnt();
    send_byte(C_STEP);
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    chk("step_rx_ready", o_rx_ready, 1'b0);
    chk("step_clk_en", o_clk_en, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("step_done", o_done, 1'b1);
    chk("step_clk_off", o_clk_en, 1'b0);
    chk("step_clk_cycles", n_clk, 1);
    @(negedge clk);

    // Noise in IDLE, then run with noise and abort
    clr_cnt();
    send_byte(8'h41);
    repeat (2) @(negedge clk);
    chk("noise_busy", o_busy, 1'b0);
    chk("noise_no_done", n_done, 0);
    send_byte(C_RUN);
    send_byte(8'h41);
    send_byte(C_ABORT);
    wait_done(50);
    @(negedge clk);
    chk("abort_stall_cycles", n_stall, 4);
    chk("abort_done", n_done, 1);

    // Reset in the middle of a word
    clr_cnt();
    send_byte(C_LOAD);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rx_ready", o_rx_ready, 1'b1);
    chk("mid_rst_pipe_reset", o_pipe_reset, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_write_en", o_write_en, 1'b0);
    chk("mid_rst_addr", o_addr_wr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_writes", n_wr, 0);

    // Length clamp: 0xFF requested, 64 words taken, then IDLE commands
    clr_cnt();
    load_prog(255, 0);
    send_byte(8'h41);
    send_byte(C_STEP);
    wait_done(20);
    @(negedge clk);
    chk("clamp_writes", n_wr, 64);
    chk("clamp_last_addr", last_wr_addr, 8'hFC);
    chk("clamp_step_clk", n_clk, 1);

    // Randomized command traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: load_prog($urandom_range(0, 5), 2);
        1: begin
          instr = rand_nonhalt();
          send_byte(C_RUN, $urandom_range(0, 2));
          k = $urandom_range(0, 6);
          repeat (k) begin instr = rand_nonhalt(); @(negedge clk); end
          instr = HALT;
          wait_done(40);
          instr = rand_nonhalt();
        end
        2: begin
          instr = rand_nonhalt();
          send_byte(C_RUN, $urandom_range(0, 2));
          k = $urandom_range(0, 4);
          repeat (k) begin instr = rand_nonhalt(); @(negedge clk); end
          if ($urandom_range(0, 1) == 1) send_byte(noise_byte(1'b0));
          send_byte(C_ABORT, $urandom_range(0, 2));
          wait_done(40);
        end
        3: begin
          instr = ($urandom_range(0, 1) == 1) ? HALT : rand_nonhalt();
          send_byte(C_STEP, $urandom_range(0, 2));
          wait_done(5);
          @(negedge clk);
          instr = rand_nonhalt();
        end
        default: send_byte(noise_byte(1'b1), $urandom_range(0, 2));
      endcase
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
